// File: rtl/audio_pkg.sv
// Shared audio package: FIFO geometry, default sample width, common types.
package audio_pkg;
    localparam int AUDIO_FIFO_DEPTH      = 128;
    localparam int AUDIO_FIFO_ADDR_WIDTH = 7;
    localparam int AUDIO_DATA_WIDTH_DFLT = 16;

    typedef logic [AUDIO_DATA_WIDTH_DFLT-1:0] audio_sample_t;

    // Channel index used to steer FIFO pops and slot loads.
    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } audio_ch_e;
endpackage

// File: rtl/audio_out_bit_counter.sv
// Per-slot bit counter: reloads on every LRCK edge, counts down on BCLK
// falling edges, and drops counting after the last bit of the slot.
// A reload wins over a coincident BCLK falling edge, so no shift occurs then.
module audio_out_bit_counter #(
    parameter logic [4:0] BIT_COUNTER_INIT = 5'h0F
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic bit_clk_falling_edge,
    output logic counting,
    output logic shift_en
);
    logic [4:0] count;

    assign shift_en = bit_clk_falling_edge & counting & ~load;

    // Reload on slot start, decrement per emitted bit, stop after bit 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            counting <= 1'b0;
        end else if (load) begin
            count    <= BIT_COUNTER_INIT;
            counting <= 1'b1;
        end else if (bit_clk_falling_edge && counting) begin
            if (count == '0) counting <= 1'b0;
            else             count    <= count - 1'b1;
        end
    end
endmodule

// File: rtl/audio_sync_fifo.sv
// Single-clock show-ahead FIFO: rd_data always presents the head entry.
// A push on a full FIFO and a pop on an empty FIFO are ignored; full and
// empty are sampled before that cycle's pop/push.
module audio_sync_fifo #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W-1:0] used
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count;
    logic              push, pop;

    assign push    = wr_en & ~full;
    assign pop     = rd_en & ~empty;
    assign empty   = (count == '0);
    assign full    = count[ADDR_W];
    assign used    = count[ADDR_W-1:0];
    assign rd_data = mem[rd_ptr];

    // Storage array, no reset needed: contents are only read when count says valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/audio_out_serializer.sv
// Audio DAC serializer: two 128-deep sample FIFOs feeding an MSB-first
// shift register framed by LRCK (slot load) and BCLK falling edges (shift).
// Optional feature macro: AUDIO_OUT_UNDERFLOW_REPEAT_EN -- an underflow slot
// repeats the last sample popped for that channel instead of sending zeros.
module audio_out_serializer
    import audio_pkg::*;
#(
    parameter int         AUDIO_DATA_WIDTH = AUDIO_DATA_WIDTH_DFLT,
    parameter logic [4:0] BIT_COUNTER_INIT = 5'h0F
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        bit_clk_rising_edge,
    input  logic                        bit_clk_falling_edge,
    input  logic                        left_right_clk_rising_edge,
    input  logic                        left_right_clk_falling_edge,
    input  logic                        done_channel_sync,
    input  logic [AUDIO_DATA_WIDTH-1:0] left_channel_data,
    input  logic [AUDIO_DATA_WIDTH-1:0] right_channel_data,
    input  logic                        write_left_audio_data_en,
    input  logic                        write_right_audio_data_en,
    output logic [7:0]                  left_audio_fifo_write_space,
    output logic [7:0]                  right_audio_fifo_write_space,
    output logic                        serial_audio_out_data
);
    localparam int NUM_CH = 2;
    localparam int W      = AUDIO_DATA_WIDTH;

    logic [NUM_CH-1:0][W-1:0]                     ch_wdata, ch_head;
    logic [NUM_CH-1:0]                            ch_wen, ch_pop, ch_empty, ch_full;
    logic [NUM_CH-1:0][AUDIO_FIFO_ADDR_WIDTH-1:0] ch_used;
    logic [NUM_CH-1:0][7:0]                       ch_wspace;

    logic            load, counting, shift_en;
    audio_ch_e       load_ch;
    logic [W-1:0]    load_word;
    logic [W-1:0]    shift_reg;
    logic            unused_in;

    // BCLK rising edges carry no information for the transmit path.
    assign unused_in = bit_clk_rising_edge;

    assign ch_wdata = {right_channel_data, left_channel_data};
    assign ch_wen   = {write_right_audio_data_en, write_left_audio_data_en};
    assign left_audio_fifo_write_space  = ch_wspace[CH_LEFT];
    assign right_audio_fifo_write_space = ch_wspace[CH_RIGHT];

    // LRCK rising starts the left slot, falling starts the right slot.
    assign load    = left_right_clk_rising_edge | left_right_clk_falling_edge;
    assign load_ch = left_right_clk_rising_edge ? CH_LEFT : CH_RIGHT;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        audio_sync_fifo #(
            .DATA_W (W),
            .ADDR_W (AUDIO_FIFO_ADDR_WIDTH)
        ) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .wr_en   (ch_wen[i]),
            .wr_data (ch_wdata[i]),
            .rd_en   (ch_pop[i]),
            .rd_data (ch_head[i]),
            .empty   (ch_empty[i]),
            .full    (ch_full[i]),
            .used    (ch_used[i])
        );
    end

    // Pop the loading channel only when synced and it has a sample.
    always_comb begin
        ch_pop = '0;
        for (int i = 0; i < NUM_CH; i++)
            ch_pop[i] = load && (int'(load_ch) == i) && done_channel_sync && !ch_empty[i];
    end

    // Free entries, registered; the 8-bit used count is {full, used[6:0]}.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (reset) ch_wspace[i] <= '0;
            else       ch_wspace[i] <= 8'(AUDIO_FIFO_DEPTH) - {ch_full[i], ch_used[i]};
        end
    end

`ifdef AUDIO_OUT_UNDERFLOW_REPEAT_EN
    logic [NUM_CH-1:0][W-1:0] last_sample;

    // Remember the last sample popped per channel for underflow repeat.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (reset)          last_sample[i] <= '0;
            else if (ch_pop[i]) last_sample[i] <= ch_head[i];
        end
    end

    // Slot word: head when available, last sample on a synced underflow.
    always_comb begin
        load_word = '0;
        if (done_channel_sync && !ch_empty[load_ch]) load_word = ch_head[load_ch];
        else if (done_channel_sync)                  load_word = last_sample[load_ch];
    end
`else
    // Slot word: head when available, zeros on underflow or when not synced.
    always_comb begin
        load_word = '0;
        if (done_channel_sync && !ch_empty[load_ch]) load_word = ch_head[load_ch];
    end
`endif

    audio_out_bit_counter #(
        .BIT_COUNTER_INIT (BIT_COUNTER_INIT)
    ) u_bit_counter (
        .clk                  (clk),
        .reset                (reset),
        .load                 (load),
        .bit_clk_falling_edge (bit_clk_falling_edge),
        .counting             (counting),
        .shift_en             (shift_en)
    );

    // Load on LRCK edges, shift MSB out on BCLK falls, idle low between slots.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg             <= '0;
            serial_audio_out_data <= 1'b0;
        end else if (load) begin
            shift_reg <= load_word;
        end else if (shift_en) begin
            serial_audio_out_data <= shift_reg[W-1];
            shift_reg             <= {shift_reg[W-2:0], 1'b0};
        end else if (bit_clk_falling_edge && !counting) begin
            serial_audio_out_data <= 1'b0;
        end
    end
endmodule

// File: tb/tb_audio_out_serializer.sv
// Scoreboard bench for audio_out_serializer. The driver generates BCLK/LRCK
// edge pulses, writes samples, and runs a queue-based model of the FIFOs to
// predict each slot word; a monitor reassembles serial bits per slot and
// compares against the predicted words.
module tb_audio_out_serializer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        bclk_rise = 1'b0, bclk_fall = 1'b0;
    logic        lr_rise = 1'b0, lr_fall = 1'b0;
    logic        sync = 1'b0;
    logic [15:0] dl = '0, dr = '0;
    logic        wl = 1'b0, wr = 1'b0;
    logic [7:0]  ws_l, ws_r;
    logic        serial;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] ql[$], qr[$], exp_q[$];
    logic [15:0] last_l = '0, last_r = '0;
    int          gcyc = 0;
    bit          gen_en = 1'b0;

    always #5 clk = ~clk;

    audio_out_serializer dut (
        .clk                          (clk),
        .reset                        (reset),
        .bit_clk_rising_edge          (bclk_rise),
        .bit_clk_falling_edge         (bclk_fall),
        .left_right_clk_rising_edge   (lr_rise),
        .left_right_clk_falling_edge  (lr_fall),
        .done_channel_sync            (sync),
        .left_channel_data            (dl),
        .right_channel_data           (dr),
        .write_left_audio_data_en     (wl),
        .write_right_audio_data_en    (wr),
        .left_audio_fifo_write_space  (ws_l),
        .right_audio_fifo_write_space (ws_r),
        .serial_audio_out_data        (serial)
    );

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clk of stimulus. BCLK period = 4 clk; LRCK toggles every 32 BCLKs,
    // aligned with a BCLK falling edge. inj forces an extra LRCK rising pulse.
    task automatic step(input bit w_l, input logic [15:0] d_l,
                        input bit w_r, input logic [15:0] d_r, input bit inj);
        bit f = 0, r = 0, lrr = 0, lrf = 0, full_l, full_r;
        logic [15:0] v;
        if (gen_en) begin
            if (gcyc % 4 == 0) begin
                f = 1;
                if ((gcyc / 4) % 32 == 0) begin
                    if ((gcyc / 4) % 64 == 0) lrr = 1;
                    else                      lrf = 1;
                end
            end
            if (gcyc % 4 == 2) r = 1;
        end
        if (inj) begin lrr = 1; lrf = 0; end
        // model: full sampled before the pop, empty before the push
        full_l = (ql.size() == 128);
        full_r = (qr.size() == 128);
        if (lrr || lrf) begin
            v = '0;
            if (lrr) begin
                if (sync && ql.size() > 0) begin v = ql.pop_front(); last_l = v; end
`ifdef AUDIO_OUT_UNDERFLOW_REPEAT_EN
                else if (sync) v = last_l;
`endif
            end else begin
                if (sync && qr.size() > 0) begin v = qr.pop_front(); last_r = v; end
`ifdef AUDIO_OUT_UNDERFLOW_REPEAT_EN
                else if (sync) v = last_r;
`endif
            end
            exp_q.push_back(v);
        end
        if (w_l && !full_l) ql.push_back(d_l);
        if (w_r && !full_r) qr.push_back(d_r);
        bclk_fall = f; bclk_rise = r; lr_rise = lrr; lr_fall = lrf;
        wl = w_l; dl = d_l; wr = w_r; dr = d_r;
        if (gen_en) gcyc++;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, '0, 0);
    endtask

    task automatic check_ws(input string tag);
        bit g = gen_en;
        gen_en = 0;
        idle(3);
        check({tag, "_ws_left"},  int'(ws_l), 128 - ql.size());
        check({tag, "_ws_right"}, int'(ws_r), 128 - qr.size());
        gen_en = g;
    endtask

    // Monitor: reassemble each slot's first 16 bits and check the tail is zero.
    bit          mon_f, mon_l, m_active = 0, m_tail = 0;
    int          m_n = 0;
    logic [15:0] m_word = '0, m_cur = '0;
    always @(posedge clk) begin
        mon_f = bclk_fall;
        mon_l = lr_rise | lr_fall;
        #2;
        if (reset) begin
            m_active = 0;
        end else if (mon_l) begin
            if (m_active) begin
                if (m_n < 16) check("slot_aborted_prefix", int'(m_word), int'(m_cur) >> (16 - m_n));
                else          check("slot_tail_zero", int'(m_tail), 0);
            end
            if (exp_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL slot_expect: got a slot load, expected none queued");
                m_cur = '0;
            end else begin
                m_cur = exp_q.pop_front();
            end
            m_active = 1; m_n = 0; m_word = '0; m_tail = 0;
        end else if (mon_f && m_active) begin
            if (m_n < 16) begin
                m_word = {m_word[14:0], serial};
                m_n++;
                if (m_n == 16) check("slot_word", int'(m_word), int'(m_cur));
            end else if (serial) begin
                m_tail = 1;
            end
        end
    end

    task automatic do_reset();
        gen_en = 0;
        reset = 1;
        @(posedge clk); #1;
        check("rst_ws_left", int'(ws_l), 0);
        check("rst_ws_right", int'(ws_r), 0);
        check("rst_serial", int'(serial), 0);
        @(posedge clk); #1;
        ql.delete(); qr.delete(); exp_q.delete();
        last_l = '0; last_r = '0; gcyc = 0;
        reset = 0;
    endtask

    initial begin
        // reset and idle
        do_reset();
        idle(10);
        check("idle_ws_left", int'(ws_l), 128);
        check("idle_ws_right", int'(ws_r), 128);
        check("idle_serial", int'(serial), 0);

        // one LRCK period with a known left/right pair
        sync = 1;
        step(1, 16'hA5C3, 1, 16'h0F01, 0);
        check_ws("pair");
        gen_en = 1; idle(256); gen_en = 0;
        check_ws("pair_drained");

        // overfill left: 130 writes, 2 dropped, then 128 slots drain it
        for (int i = 1; i <= 130; i++) step(1, 16'(i), 0, '0, 0);
        check_ws("overfill");
        gen_en = 1; idle(128 * 256); gen_en = 0;
        check_ws("overfill_drained");

        // underflow slots, then one real sample followed by underflow
        gen_en = 1; idle(512); gen_en = 0;
        step(1, 16'h1234, 0, '0, 0);
        gen_en = 1; idle(512); gen_en = 0;

        // not synced: samples held, zeros sent; then sync and drain
        sync = 0;
        for (int i = 0; i < 4; i++) step(1, 16'($urandom), 0, '0, 0);
        gen_en = 1; idle(256); gen_en = 0;
        check_ws("unsynced");
        sync = 1;
        gen_en = 1; idle(256); gen_en = 0;
        check_ws("synced_drained");

        // injected LRCK edges: mid-slot abort and one coincident with a BCLK fall
        for (int i = 0; i < 6; i++) step(1, 16'($urandom), 1, 16'($urandom), 0);
        gen_en = 1;
        for (int i = 0; i < 768; i++) step(0, '0, 0, '0, (i == 21) || (i == 160) || (i == 256 + 45));
        gen_en = 0;
        check_ws("inject");

        // randomized writes with occasional sync changes while running
        gen_en = 1;
        for (int i = 0; i < 2048; i++) begin
            if ($urandom_range(199) == 0) sync = ~sync;
            step($urandom_range(7) == 0, 16'($urandom), $urandom_range(7) == 0, 16'($urandom), 0);
        end
        sync = 1;
        check_ws("random");

        // reset in the middle of a slot, then recover
        for (int i = 0; i < 8; i++) step(1, 16'hFFFF, 1, 16'hFFFF, 0);
        gen_en = 1; idle(256 + 4 * 6); gen_en = 0;
        do_reset();
        idle(3);
        check("post_rst_ws_left", int'(ws_l), 128);
        check("post_rst_ws_right", int'(ws_r), 128);
        check("post_rst_serial", int'(serial), 0);
        step(1, 16'hC001, 1, 16'h8421, 0);
        gen_en = 1; idle(256); gen_en = 0;
        check_ws("post_rst_run");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/audio_out_serializer.md
# audio_out_serializer

Transmit-side counterpart of the audio ADC deserializer: buffers left/right PCM samples written by the host/DMA side in two 128-deep FIFOs and shifts them MSB-first onto the audio DAC serial data line, framed by the codec's bit clock and left/right clock. It sits between the audio core's register/stream interface and the DAC pin. Edge pulses come from the shared clock-edge detectors.

## Interface
- AUDIO_DATA_WIDTH, 16, sample width in bits
- BIT_COUNTER_INIT, 5'h0F, bits per channel slot minus one (slot = BIT_COUNTER_INIT+1 bits)
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high; clock clk
- bit_clk_rising_edge / bit_clk_falling_edge  in  1  one-cycle pulses of BCLK edges
- left_right_clk_rising_edge / left_right_clk_falling_edge  in  1  one-cycle pulses of LRCK edges
- done_channel_sync  in  1  high once LRCK alignment is established; gates FIFO pops
- left_channel_data / right_channel_data  in  AUDIO_DATA_WIDTH  sample to write
- write_left_audio_data_en / write_right_audio_data_en  in  1  write strobe, one sample per cycle
- left_audio_fifo_write_space / right_audio_fifo_write_space  out  8  free entries, 0..128
- serial_audio_out_data  out  1  DAC serial data

## Operation
- Write: strobe high and FIFO not full -> push. Strobe while full -> dropped, no state change.
- Write space = 128 - words_used, where words_used = {full, used[6:0]}. Registered.
- Slot load on LRCK rising edge (left slot) / falling edge (right slot):
  - If done_channel_sync and the channel FIFO is non-empty: shift_reg <= FIFO head (first-word-fall-through) and pop that cycle.
  - Otherwise (empty, or not synced): shift_reg <= 0 and no pop.
- Bit counter, in the same cycle as the load: count <= BIT_COUNTER_INIT and counting <= 1.
- On bit_clk_falling_edge while counting:
  - serial_audio_out_data <= shift_reg MSB, then shift_reg shifts left with 0 fill.
  - If count == 0, counting <= 0; else count decrements.
  - Exactly BIT_COUNTER_INIT+1 bits are emitted per slot.
- On bit_clk_falling_edge while not counting: serial_audio_out_data <= 0.
- If BIT_COUNTER_INIT+1 > AUDIO_DATA_WIDTH, the trailing bits are zero. If it is smaller, the sample's LSBs are truncated.

## Timing
- Reset: both write_space outputs = 0 (128 from the first cycle after reset); serial_audio_out_data = 0; shift_reg = 0; counting = 0; both FIFOs empty.
- Write-to-write_space latency: 1 clk.
- A written sample is eligible at the next matching LRCK edge provided the write happened at least 1 clk earlier.
- LRCK edge coincident with a BCLK falling edge: the load has priority and no shift occurs that cycle. The first bit appears on the next BCLK falling edge.
- Push and pop in the same cycle on a full FIFO: the pop occurs and the push is dropped (full is sampled before the pop). On an empty FIFO: the push is accepted and the slot loads zero.
- LRCK edge arriving mid-slot (count != 0): abort the slot, reload, restart counting.
- done_channel_sync falling mid-operation: the current slot completes. Subsequent slots load zero and the FIFOs retain their contents.
- Reset mid-slot: the FIFOs flush and the output is forced to 0 on the next clk.

## Configuration
- AUDIO_OUT_UNDERFLOW_REPEAT_EN defined: on an underflow (synced, FIFO empty), the slot reloads the last sample popped for that channel. The per-channel last-sample registers reset to 0.
- Not defined: an underflow slot transmits zeros, and no last-sample registers exist.

## Structure
- Shared package audio_pkg:
  - AUDIO_FIFO_DEPTH = 128 and AUDIO_FIFO_ADDR_WIDTH = 7.
  - Default AUDIO_DATA_WIDTH.
  - Typedef audio_sample_t.
- Sub-module audio_out_bit_counter: LRCK-edge reload, BCLK-falling decrement, counting output.
- The two channel FIFOs are instances of the team's existing synchronous FIFO (show-ahead mode).

## Test plan
- Reset, then idle 10 clk -> both write_space = 128 and serial_audio_out_data = 0.
- Sync high; write left 16'hA5C3 and right 16'h0F01; run one LRCK period -> serial bits on BCLK falling edges read 1010010111000011 then 0000111100000001; write_space returns to 128.
- Write 130 left samples with no pops -> write_space = 0 after 128; the 2 extra samples are dropped; the next 128 left slots output samples 1..128 in order.
- Empty FIFOs, sync high -> slots are all-zero. With AUDIO_OUT_UNDERFLOW_REPEAT_EN, after one slot of 16'h1234 the underflow slots repeat 16'h1234.
- done_channel_sync low with 4 samples queued -> output zeros and write_space = 124. After sync rises, the first sample emits at the next LRCK rising edge.
- LRCK edge coincident with a BCLK falling edge, plus an LRCK edge injected mid-slot -> no shift on the coincident cycle, the slot restarts with a full BIT_COUNTER_INIT+1 bits, and the aborted sample stays popped.
